// File: rtl/reg_bus_pkg.sv
// Shared widths, FSM encoding and latched-transaction type for the register-bus arbiter.
package reg_bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;
endpackage

// File: rtl/reg_arbiter_if.sv
// Requester-side handshake plus register-bus signals; slave = arbiter, master = environment.
interface reg_arbiter_if #(parameter int NREQ = 4);
  import reg_bus_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [ADDR_W*NREQ-1:0] req_addr;
  logic [DATA_W*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [ADDR_W-1:0]      reg_addr;
  logic [DATA_W-1:0]      reg_wdata;
  logic                   reg_wr;
  logic                   reg_rd;
  logic [DATA_W-1:0]      reg_rdata;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, reg_rdata,
    output ack, rdata, busy, reg_addr, reg_wdata, reg_wr, reg_rd
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, reg_rdata,
    input  ack, rdata, busy, reg_addr, reg_wdata, reg_wr, reg_rd
  );
endinterface

// File: rtl/reg_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past the last winner and wraps.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!valid && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        valid     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one register bus, one transaction at a time.
module reg_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  reg_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  txn_t              txn_q, txn_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;

  logic [NREQ-1:0]              pick_gnt;
  logic [IDX_W-1:0]             pick_idx;
  logic                         pick_vld;
  logic [NREQ-1:0][ADDR_W-1:0]  addr_arr;
  logic [NREQ-1:0][DATA_W-1:0]  wdata_arr;

  assign addr_arr  = bus.req_addr;
  assign wdata_arr = bus.req_wdata;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        win_d       = pick_idx;
        txn_d.wr    = bus.req_wr[pick_idx];
        txn_d.addr  = addr_arr[pick_idx];
        txn_d.wdata = wdata_arr[pick_idx];
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: if (txn_q.wr) begin
        state_d = ST_DONE;
      end else begin
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: if (cnt_q == '0) begin
        rdata_d = bus.reg_rdata;
        state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    busy_d      = (state_d != ST_IDLE);
    reg_wr_d    = (state_d == ST_ISSUE) &&  txn_d.wr;
    reg_rd_d    = (state_d == ST_ISSUE) && !txn_d.wr;
    reg_addr_d  = (state_d == ST_ISSUE || state_d == ST_WAIT) ? txn_d.addr : '0;
    reg_wdata_d = reg_wr_d ? txn_d.wdata : '0;
    ack_d       = (state_d == ST_DONE) ? (NREQ'(1) << win_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      txn_q       <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      txn_q       <= txn_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench: stimulus queues expected bus strobes and acks with their cycle numbers,
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_reg_arbiter;
  localparam int NREQ   = 4;
  localparam int RD_LAT = 3;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] ack;
    logic [31:0]     rdata;
  } ack_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  int   rcnt;

  logic [NREQ-1:0]        req_v;
  logic [NREQ-1:0]        wr_v;
  logic [NREQ-1:0][15:0]  addr_v;
  logic [NREQ-1:0][31:0]  wd_v;

  strobe_t sq[$];
  ack_t    aq[$];
  strobe_t s;
  ack_t    a;

  reg_arbiter_if #(.NREQ(NREQ)) bus ();

  reg_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply();
    bus.req       = req_v;
    bus.req_wr    = wr_v;
    bus.req_addr  = addr_v;
    bus.req_wdata = wd_v;
  endtask

  task automatic drive(input logic [1:0] i, input bit wr, input logic [15:0] ad, input logic [31:0] d);
    wr_v[i]   = wr;
    addr_v[i] = ad;
    wd_v[i]   = d;
    req_v[i]  = 1'b1;
    apply();
  endtask

  task automatic drop(input logic [1:0] i);
    req_v[i] = 1'b0;
    apply();
  endtask

  task automatic exp_strobe(input int c, input bit wr, input logic [15:0] ad, input logic [31:0] d);
    strobe_t e;
    e.cyc = c; e.wr = wr; e.addr = ad; e.wdata = d;
    sq.push_back(e);
  endtask

  task automatic exp_ack(input int c, input logic [1:0] i, input logic [31:0] rd);
    ack_t e;
    e.cyc = c; e.ack = NREQ'(1) << i; e.rdata = rd;
    aq.push_back(e);
  endtask

  function automatic logic [31:0] rd_model(input logic [15:0] ad);
    return (ad == 16'h0004) ? 32'h1234_5678 : {~ad, ad};
  endfunction

  // Register-bus slave: read data is valid only in the cycle RD_LAT after the reg_rd cycle.
  initial begin
    rcnt = 0;
    bus.reg_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (bus.reg_rd) rcnt = RD_LAT + 1;
      else if (rcnt > 0) rcnt--;
      bus.reg_rdata = (rcnt == 1) ? rd_model(bus.reg_addr) : 32'hBAD0_BAD0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("quiet_invariants",
            64'({bus.reg_wr & bus.reg_rd,
                 !bus.busy && (bus.reg_addr != 0 || bus.ack != 0 || bus.reg_wr || bus.reg_rd),
                 !bus.reg_wr && bus.reg_wdata != 0}), 64'd0);
        if (bus.reg_wr || bus.reg_rd) begin
          if (sq.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
          else begin
            s = sq.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
            chk("strobe_kind", 64'({bus.reg_wr, bus.reg_rd}), 64'({s.wr, !s.wr}));
            chk("strobe_addr", 64'(bus.reg_addr), 64'(s.addr));
            chk("strobe_wdata", 64'(bus.reg_wdata), 64'(s.wr ? s.wdata : 32'h0));
            chk("strobe_busy", 64'(bus.busy), 64'd1);
          end
        end
        if (bus.ack != 0) begin
          if (aq.size() == 0) chk("unexpected_ack", 64'(bus.ack), 64'd0);
          else begin
            a = aq.pop_front();
            chk("ack_cycle", 64'(cyc), 64'(a.cyc));
            chk("ack_vector", 64'(bus.ack), 64'(a.ack));
            chk("ack_rdata", 64'(bus.rdata), 64'(a.rdata));
          end
        end
      end
    end
  end

  initial begin
    int n;
    cyc = 0; checks = 0; failures = 0; mon_en = 1'b0;
    reset_n = 1'b0;
    req_v = '0; wr_v = '0; addr_v = '0; wd_v = '0;
    apply();
    tick(1);
    mon_en = 1'b1;
    tick(1);
    @(negedge clk);
    chk("reset_outputs", 64'({bus.busy, bus.ack, bus.reg_wr, bus.reg_rd, bus.reg_addr}), 64'd0);
    chk("reset_data", 64'({bus.reg_wdata, bus.rdata}), 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

    // Idle: nothing requested
    repeat (20) begin
      @(negedge clk);
      chk("idle_quiet", 64'({bus.busy, bus.reg_wr, bus.reg_rd, bus.ack}), 64'd0);
    end
    tick(1);

    // Single write from requester 2
    n = cyc;
    exp_strobe(n + 1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    exp_ack(n + 2, 2'd2, 32'h0);
    drive(2'd2, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    tick(2); drop(2'd2); tick(2);

    // Single read from requester 1
    n = cyc;
    exp_strobe(n + 1, 1'b0, 16'h0004, 32'h0);
    exp_ack(n + 5, 2'd1, 32'h1234_5678);
    drive(2'd1, 1'b0, 16'h0004, 32'h0);
    tick(5); drop(2'd1); tick(2);

    // Inputs change after latching; rdata must survive a write
    n = cyc;
    exp_strobe(n + 1, 1'b1, 16'h0020, 32'hAAAA_0000);
    exp_ack(n + 2, 2'd0, 32'h1234_5678);
    drive(2'd0, 1'b1, 16'h0020, 32'hAAAA_0000);
    tick(1);
    addr_v[0] = 16'hFFFF; wd_v[0] = 32'h5555_FFFF; wr_v[0] = 1'b0;
    apply();
    tick(1); drop(2'd0); tick(2);

    // Second read updates rdata
    n = cyc;
    exp_strobe(n + 1, 1'b0, 16'h0008, 32'h0);
    exp_ack(n + 5, 2'd3, 32'hFFF7_0008);
    drive(2'd3, 1'b0, 16'h0008, 32'h0);
    tick(5); drop(2'd3); tick(2);

    // Contention: all four held, last winner 3 -> 0,1,2,3,0
    n = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_strobe(n + 1 + 3*k, 1'b1, 16'h0100 + 16'(k % 4), 32'hC0DE_0000 + 32'(k % 4));
      exp_ack(n + 2 + 3*k, 2'(k), 32'hFFF7_0008);
    end
    for (int k = 0; k < 4; k++) drive(2'(k), 1'b1, 16'h0100 + 16'(k), 32'hC0DE_0000 + 32'(k));
    tick(14);
    req_v = '0; apply();
    tick(2);

    // Requester drops req during ISSUE; ack still delivered
    n = cyc;
    exp_strobe(n + 1, 1'b1, 16'h0050, 32'h0BAD_F00D);
    exp_ack(n + 2, 2'd1, 32'hFFF7_0008);
    drive(2'd1, 1'b1, 16'h0050, 32'h0BAD_F00D);
    tick(1); drop(2'd1); tick(3);

    // Reset during WAIT abandons the read
    n = cyc;
    exp_strobe(n + 1, 1'b0, 16'h0030, 32'h0);
    drive(2'd2, 1'b0, 16'h0030, 32'h0);
    tick(2);
    reset_n = 1'b0;
    drop(2'd2);
    tick(1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 64'({bus.busy, bus.ack, bus.reg_wr, bus.reg_rd, bus.reg_addr}), 64'd0);
    chk("midreset_data", 64'({bus.reg_wdata, bus.rdata}), 64'd0);
    tick(5);

    // After reset requester 0 wins over 3, then 3 is served
    n = cyc;
    exp_strobe(n + 1, 1'b1, 16'h0040, 32'h3333_4444);
    exp_ack(n + 2, 2'd0, 32'h0);
    exp_strobe(n + 4, 1'b1, 16'h0044, 32'h5555_6666);
    exp_ack(n + 5, 2'd3, 32'h0);
    drive(2'd0, 1'b1, 16'h0040, 32'h3333_4444);
    drive(2'd3, 1'b1, 16'h0044, 32'h5555_6666);
    tick(2); drop(2'd0);
    tick(3); drop(2'd3);
    tick(4);

    chk("pending_strobes", 64'(sq.size()), 64'd0);
    chk("pending_acks", 64'(aq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
